// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-style control FSM with an instruction counter.
// Optional feature: define MCTRL_MEMWAIT_EN so FETCH/MEMACC wait for mem_ready.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        PCWrCond,
  output logic [1:0]  PCSrc,
  output logic        IRWr,
  output logic        MemR,
  output logic        MemW,
  output logic        RegW,
  output logic        Mem2R,
  output logic [1:0]  RegDst,
  output logic [1:0]  AluPhase,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMACC = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_done_s;
  logic        is_rtype_s, is_ralu_s, is_jr_s, is_itype_s, is_lw_s, is_sw_s;
  logic        is_beq_s, is_bne_s, is_j_s, is_jal_s;

`ifdef MCTRL_MEMWAIT_EN
  assign mem_done_s = mem_ready;
`else
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign mem_done_s = 1'b1;
`endif

  assign is_rtype_s = (OpCode == 6'b000000);
  assign is_jr_s    = is_rtype_s && (funct == 6'b001000);
  assign is_lw_s    = (OpCode == 6'b100011);
  assign is_sw_s    = (OpCode == 6'b101011);
  assign is_beq_s   = (OpCode == 6'b000100);
  assign is_bne_s   = (OpCode == 6'b000101);
  assign is_j_s     = (OpCode == 6'b000010);
  assign is_jal_s   = (OpCode == 6'b000011);

  always_comb begin
    is_ralu_s = 1'b0;
    if (is_rtype_s) begin
      case (funct)
        6'b100001, 6'b100000, 6'b100011, 6'b100010, 6'b101010,
        6'b000000, 6'b000010, 6'b000011, 6'b100100, 6'b100101: is_ralu_s = 1'b1;
        default: is_ralu_s = 1'b0;
      endcase
    end else begin
      is_ralu_s = 1'b0;
    end
  end

  always_comb begin
    case (OpCode)
      6'b001101, 6'b001000, 6'b001111, 6'b001010: is_itype_s = 1'b1;
      default:                                    is_itype_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are forced low during reset because FETCH would otherwise assert MemR/IRWr/PCWr.
  always_comb begin
    state_d    = state_q;
    PCWr       = 1'b0;
    PCWrCond   = 1'b0;
    PCSrc      = 2'b00;
    IRWr       = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    RegW       = 1'b0;
    Mem2R      = 1'b0;
    RegDst     = 2'b00;
    AluPhase   = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemR = 1'b1;
          if (mem_done_s) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          AluPhase = 2'b01;
          if (is_ralu_s || is_itype_s || is_lw_s || is_sw_s) begin
            state_d = S_EXEC;
          end else if (is_beq_s || is_bne_s) begin
            state_d = S_BRANCH;
          end else if (is_j_s || is_jal_s || is_jr_s) begin
            state_d = S_JUMP;
          end else begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_EXEC: begin
          AluPhase = 2'b10;
          state_d  = (is_lw_s || is_sw_s) ? S_MEMACC : S_WB;
        end
        S_MEMACC: begin
          MemR = is_lw_s;
          MemW = is_sw_s;
          if (!mem_done_s) begin
            state_d = S_MEMACC;
          end else if (is_lw_s) begin
            state_d = S_WB;
          end else begin
            instr_done = is_sw_s;
            state_d    = S_FETCH;
          end
        end
        S_WB: begin
          RegW       = 1'b1;
          instr_done = 1'b1;
          RegDst     = is_rtype_s ? 2'b00 : 2'b01;
          Mem2R      = is_lw_s;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          PCSrc      = 2'b01;
          instr_done = 1'b1;
          PCWrCond   = (is_beq_s && Zero) || (is_bne_s && !Zero);
          state_d    = S_FETCH;
        end
        S_JUMP: begin
          PCWr       = 1'b1;
          instr_done = 1'b1;
          PCSrc      = is_jr_s ? 2'b11 : 2'b10;
          RegW       = is_jal_s;
          RegDst     = is_jal_s ? 2'b10 : 2'b00;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign cnt_d     = instr_done ? (cnt_q + 32'd1) : cnt_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, reset corners and random instructions.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode, funct;
  logic        Zero, mem_ready;
  logic        PCWr, PCWrCond, IRWr, MemR, MemW, RegW, Mem2R, instr_done, illegal;
  logic [1:0]  PCSrc, RegDst, AluPhase;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_cnt  = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc),
    .IRWr(IRWr), .MemR(MemR), .MemW(MemW), .RegW(RegW), .Mem2R(Mem2R),
    .RegDst(RegDst), .AluPhase(AluPhase), .state(state),
    .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {C_RT, C_IT, C_LW, C_SW, C_BR, C_JMP, C_ILL} cls_e;

  // Output vector: {state, PCWr, PCWrCond, PCSrc, IRWr, MemR, MemW, RegW, Mem2R, RegDst, AluPhase, done, illegal}
  function automatic logic [17:0] vec(input logic [2:0] st, input logic pcwr, input logic pcwrc,
                                      input logic [1:0] pcsrc, input logic irwr, input logic memr,
                                      input logic memw, input logic regw, input logic mem2r,
                                      input logic [1:0] regdst, input logic [1:0] alu,
                                      input logic done, input logic ill);
    return {st, pcwr, pcwrc, pcsrc, irwr, memr, memw, regw, mem2r, regdst, alu, done, ill};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {state, PCWr, PCWrCond, PCSrc, IRWr, MemR, MemW, RegW, Mem2R, RegDst, AluPhase,
            instr_done, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn inside {6'b100001, 6'b100000, 6'b100011, 6'b100010, 6'b101010,
                     6'b000000, 6'b000010, 6'b000011, 6'b100100, 6'b100101}) return C_RT;
      if (fn == 6'b001000) return C_JMP;
      return C_ILL;
    end
    if (op inside {6'b001101, 6'b001000, 6'b001111, 6'b001010}) return C_IT;
    if (op == 6'b100011) return C_LW;
    if (op == 6'b101011) return C_SW;
    if (op inside {6'b000100, 6'b000101}) return C_BR;
    if (op inside {6'b000010, 6'b000011}) return C_JMP;
    return C_ILL;
  endfunction

  // The sequence of states each instruction class walks through.
  function automatic logic [2:0] path_state(input cls_e c, input int step);
    int p [7][5] = '{'{0,1,2,4,0}, '{0,1,2,4,0}, '{0,1,2,3,4}, '{0,1,2,3,0},
                     '{0,1,5,0,0}, '{0,1,6,0,0}, '{0,1,0,0,0}};
    return 3'(p[int'(c)][step]);
  endfunction

  function automatic logic [17:0] model(input cls_e c, input int step, input logic [5:0] op,
                                        input logic z, input logic mem_ok);
    logic [2:0] st;
    st = path_state(c, step);
    case (st)
      3'd0: return vec(st, mem_ok, 1'b0, 2'b00, mem_ok, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      3'd1: return vec(st, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01,
                       c == C_ILL, c == C_ILL);
      3'd2: return vec(st, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);
      3'd3: return vec(st, 1'b0, 1'b0, 2'b00, 1'b0, c == C_LW, c == C_SW, 1'b0, 1'b0, 2'b00, 2'b00,
                       (c == C_SW) && mem_ok, 1'b0);
      3'd4: return vec(st, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, c == C_LW,
                       (op == 6'd0) ? 2'b00 : 2'b01, 2'b00, 1'b1, 1'b0);
      3'd5: return vec(st, 1'b0, (op == 6'b000100) ? z : !z, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       2'b00, 2'b00, 1'b1, 1'b0);
      default: return vec(st, 1'b1, 1'b0, (op == 6'd0) ? 2'b11 : 2'b10, 1'b0, 1'b0, 1'b0,
                          op == 6'b000011, 1'b0, (op == 6'b000011) ? 2'b10 : 2'b00, 2'b00, 1'b1, 1'b0);
    endcase
  endfunction

  // Runs one instruction from FETCH, checking every cycle; reports DUT latency and done-cycle outputs.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input bit rnd_mem,
                          output int dut_cyc, output logic [17:0] last);
    cls_e c;
    int step, cyc;
    bit finished, adv;
    logic mem_ok;
    logic [17:0] e;
    c = classify(op, fn);
    OpCode = op; funct = fn; Zero = z;
    step = 0; cyc = 0; finished = 0; dut_cyc = -1; last = '0;
    while (!finished && cyc < 40) begin
      @(negedge clk);
      cyc++;
`ifdef MCTRL_MEMWAIT_EN
      mem_ok = mem_ready;
`else
      mem_ok = 1'b1;
`endif
      e = model(c, step, op, z, mem_ok);
      chk("cycle_outputs", 32'(dut_vec()), 32'(e));
      if (instr_done && dut_cyc < 0) begin
        dut_cyc = cyc;
        last = dut_vec();
      end
      if (e[1]) begin
        exp_cnt++;
        finished = 1;
      end
      adv = !(path_state(c, step) inside {3'd0, 3'd3}) || mem_ok;
      @(posedge clk); #1;
      if (adv) step++;
      if (rnd_mem) mem_ready = ($urandom_range(0, 3) != 0);
    end
    if (!finished) chk("instr_timeout", 32'd1, 32'd0);
    chk("instr_cnt", instr_cnt, 32'(exp_cnt));
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          cyc;
    logic [17:0] last;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int dc;
    logic [17:0] lv;
    logic [5:0] ops [12] = '{6'b000000, 6'b000000, 6'b001101, 6'b001000, 6'b001111, 6'b001010,
                             6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
    logic [5:0] fns [12] = '{6'b100001, 6'b100000, 6'b100011, 6'b100010, 6'b101010, 6'b000000,
                             6'b000010, 6'b000011, 6'b100100, 6'b100101, 6'b001000, 6'b000001};

    tbl[0]  = '{6'b000000, 6'b100001, 1'b0, 4, vec(4,0,0,2'b00,0,0,0,1,0,2'b00,2'b00,1,0)};
    tbl[1]  = '{6'b001101, 6'b000000, 1'b0, 4, vec(4,0,0,2'b00,0,0,0,1,0,2'b01,2'b00,1,0)};
    tbl[2]  = '{6'b100011, 6'b000000, 1'b0, 5, vec(4,0,0,2'b00,0,0,0,1,1,2'b01,2'b00,1,0)};
    tbl[3]  = '{6'b101011, 6'b000000, 1'b0, 4, vec(3,0,0,2'b00,0,0,1,0,0,2'b00,2'b00,1,0)};
    tbl[4]  = '{6'b000100, 6'b000000, 1'b1, 3, vec(5,0,1,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[5]  = '{6'b000101, 6'b000000, 1'b1, 3, vec(5,0,0,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[6]  = '{6'b000101, 6'b000000, 1'b0, 3, vec(5,0,1,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[7]  = '{6'b000100, 6'b000000, 1'b0, 3, vec(5,0,0,2'b01,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[8]  = '{6'b000011, 6'b000000, 1'b0, 3, vec(6,1,0,2'b10,0,0,0,1,0,2'b10,2'b00,1,0)};
    tbl[9]  = '{6'b000000, 6'b001000, 1'b0, 3, vec(6,1,0,2'b11,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[10] = '{6'b000010, 6'b000000, 1'b0, 3, vec(6,1,0,2'b10,0,0,0,0,0,2'b00,2'b00,1,0)};
    tbl[11] = '{6'b111111, 6'b000000, 1'b0, 2, vec(1,0,0,2'b00,0,0,0,0,0,2'b00,2'b01,1,1)};
    tbl[12] = '{6'b000000, 6'b000001, 1'b0, 2, vec(1,0,0,2'b00,0,0,0,0,0,2'b00,2'b01,1,1)};
    tbl[13] = '{6'b000000, 6'b000000, 1'b0, 4, vec(4,0,0,2'b00,0,0,0,1,0,2'b00,2'b00,1,0)};

    rst = 1'b1; OpCode = 6'd0; funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    chk("reset_cnt", instr_cnt, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_instr(tbl[i].op, tbl[i].fn, tbl[i].z, 1'b0, dc, lv);
      chk($sformatf("tbl%0d_latency", i), 32'(dc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_done_outputs", i), 32'(lv), 32'(tbl[i].last));
    end

    // Reset raised while a store sits in MEMACC.
    OpCode = 6'b101011; funct = 6'd0; Zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sw_in_memacc", 32'({state, MemW}), 32'({3'd3, 1'b1}));
    #1 rst = 1'b1;
    #1;
    chk("rst_memacc_outputs", 32'(dut_vec()), 32'd0);
    chk("rst_memacc_cnt", instr_cnt, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_instr(6'b000000, 6'b100001, 1'b0, 1'b0, dc, lv);
    chk("post_reset_addu_latency", 32'(dc), 32'd4);

    // Random instructions with random memory handshake.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
      do_instr(op, fn, 1'($urandom), 1'b1, dc, lv);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
